// File: rtl/audio_pkg.sv
// Shared types for the mic sample framer.
//   sample_t          - one raw 16-bit mic sample
//   FRAME_LEN_DEFAULT - default samples per frame
//   bank_state_t      - ping-pong bank ownership (EMPTY / FULL / READING)
//   wr_state_t        - writer FSM (FILL / WAIT)
//   rd_state_t        - reader FSM (IDLE / PRIME / STREAM)
//   pick_bank()       - chooses which FULL bank the reader drains next
package audio_pkg;

    typedef logic [15:0] sample_t;

    localparam int FRAME_LEN_DEFAULT    = 1024;
    localparam int SAMPLE_WIDTH_DEFAULT = 16;
    localparam int NUM_BANKS            = 2;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FULL    = 2'd1,
        BANK_READING = 2'd2
    } bank_state_t;

    typedef enum logic {
        WR_FILL = 1'b0,
        WR_WAIT = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_PRIME  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

    // When both banks hold a complete frame the older one goes first so
    // frames leave in the order they were captured.
    function automatic logic pick_bank(input logic [1:0] full, input logic older);
        if (full == 2'b11) begin
            return older;
        end
        return full[0] ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/framer_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks.
//   clk         - clock
//   we/waddr/wdata - write port
//   re/raddr    - read request; rdata is valid one cycle after re
//   rdata       - registered read data (held when re is low)
// The bank select is the address MSB, so one array maps onto one block RAM.
module framer_bank_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sample_framer.sv
// Ping-pong sample framer: packs mic samples into FRAME_LEN-sample frames
// and streams whole frames out over valid/ready.
//   clk_in, rst_in             - clock, synchronous active-high reset
//   sample_in, sample_valid_in - input sample stream (<= 1 strobe / 2 cycles)
//   frame_data_out             - current beat data
//   frame_valid_out            - beat valid
//   frame_ready_in             - consumer ready
//   frame_last_out             - beat is the last of its frame
//   frame_index_out            - beat position within the frame
//   drop_out                   - one-cycle pulse per discarded sample
module sample_framer
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT,
    parameter int FRAME_LEN    = FRAME_LEN_DEFAULT
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [SAMPLE_WIDTH-1:0]      sample_in,
    input  logic                         sample_valid_in,
    output logic [SAMPLE_WIDTH-1:0]      frame_data_out,
    output logic                         frame_valid_out,
    input  logic                         frame_ready_in,
    output logic                         frame_last_out,
    output logic [$clog2(FRAME_LEN)-1:0] frame_index_out,
    output logic                         drop_out
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    // ---------------- state ----------------
    wr_state_t               wr_state_reg, wr_state_next;
    logic                    wr_bank_reg, wr_bank_next;
    logic [IDX_W-1:0]        wr_idx_reg, wr_idx_next;
    bank_state_t             bank_state_reg  [NUM_BANKS];
    bank_state_t             bank_state_next [NUM_BANKS];
    logic                    older_reg, older_next;
    rd_state_t               rd_state_reg, rd_state_next;
    logic                    rd_bank_reg, rd_bank_next;
    logic [IDX_W-1:0]        rd_ptr_reg, rd_ptr_next;
    logic                    issue_more_reg, issue_more_next;
    logic                    q_valid_reg, q_valid_next;
    logic [IDX_W-1:0]        q_idx_reg, q_idx_next;
    logic                    skid_valid_reg, skid_valid_next;
    logic [SAMPLE_WIDTH-1:0] skid_data_reg, skid_data_next;
    logic [IDX_W-1:0]        skid_idx_reg, skid_idx_next;
    logic                    out_valid_reg, out_valid_next;
    logic [SAMPLE_WIDTH-1:0] out_data_reg, out_data_next;
    logic [IDX_W-1:0]        out_idx_reg, out_idx_next;
    logic                    out_last_reg, out_last_next;
    logic                    drop_reg, drop_next;

    // ---------------- control strobes ----------------
    logic                    wr_accept;
    logic                    wr_complete;
    logic                    rd_take;
    logic                    rd_release;
    logic                    fire;
    logic                    space_ok;
    logic [1:0]              occ;
    logic [1:0]              full_now;
    logic                    ram_re;
    logic [IDX_W-1:0]        ram_raddr_idx;
    logic [SAMPLE_WIDTH-1:0] ram_q;

    // A bank counts as FULL for the reader either when registered FULL or
    // when the writer is completing it this very cycle; this lets the reader
    // enter PRIME on the same edge the last sample is written.
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_full
        assign full_now[gi] = (bank_state_reg[gi] == BANK_FULL) ||
                              (wr_complete && (int'(wr_bank_reg) == gi));
    end

    framer_bank_ram #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (NUM_BANKS * FRAME_LEN)
    ) u_ram (
        .clk   (clk_in),
        .we    (wr_accept),
        .waddr ({wr_bank_reg, wr_idx_reg}),
        .wdata (sample_in),
        .re    (ram_re),
        .raddr ({rd_bank_reg, ram_raddr_idx}),
        .rdata (ram_q)
    );

    // ---------------- writer FSM ----------------
    always_comb begin
        wr_state_next = wr_state_reg;
        wr_bank_next  = wr_bank_reg;
        wr_idx_next   = wr_idx_reg;
        wr_accept     = 1'b0;
        wr_complete   = 1'b0;
        drop_next     = 1'b0;
        case (wr_state_reg)
            WR_FILL: begin
                if (sample_valid_in) begin
                    wr_accept = 1'b1;
                    if (wr_idx_reg == LAST_IDX) begin
                        wr_complete   = 1'b1;
                        wr_idx_next   = '0;
                        wr_bank_next  = ~wr_bank_reg;
                        wr_state_next = (bank_state_reg[~wr_bank_reg] == BANK_EMPTY) ?
                                        WR_FILL : WR_WAIT;
                    end else begin
                        wr_idx_next = wr_idx_reg + IDX_W'(1);
                    end
                end
            end
            WR_WAIT: begin
                // Every strobe here is lost, including one that coincides
                // with the release of the target bank (seen next cycle).
                drop_next = sample_valid_in;
                if (bank_state_reg[wr_bank_reg] == BANK_EMPTY) begin
                    wr_state_next = WR_FILL;
                end
            end
            default: wr_state_next = WR_FILL;
        endcase
    end

    // ---------------- reader FSM + output pipeline ----------------
    assign fire = out_valid_reg && frame_ready_in;
    assign occ  = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg} + {1'b0, q_valid_reg};
    // A new read may issue only if its word will have a home next cycle
    // (output register or skid), counting the word already in flight.
    assign space_ok = fire ? (occ <= 2'd2) : (occ <= 2'd1);

    always_comb begin
        rd_state_next   = rd_state_reg;
        rd_bank_next    = rd_bank_reg;
        rd_ptr_next     = rd_ptr_reg;
        issue_more_next = issue_more_reg;
        rd_take         = 1'b0;
        rd_release      = 1'b0;
        ram_re          = 1'b0;
        ram_raddr_idx   = rd_ptr_reg;
        case (rd_state_reg)
            RD_IDLE: begin
                if (|full_now) begin
                    rd_take       = 1'b1;
                    rd_bank_next  = pick_bank(full_now, older_reg);
                    rd_state_next = RD_PRIME;
                end
            end
            RD_PRIME: begin
                ram_re          = 1'b1;
                ram_raddr_idx   = '0;
                rd_ptr_next     = IDX_W'(1);
                issue_more_next = 1'b1;
                rd_state_next   = RD_STREAM;
            end
            RD_STREAM: begin
                if (issue_more_reg && space_ok) begin
                    ram_re      = 1'b1;
                    rd_ptr_next = rd_ptr_reg + IDX_W'(1);
                    if (rd_ptr_reg == LAST_IDX) begin
                        issue_more_next = 1'b0;
                    end
                end
                if (fire && out_last_reg) begin
                    rd_release = 1'b1;
                    if (full_now[~rd_bank_reg]) begin
                        rd_take       = 1'b1;
                        rd_bank_next  = ~rd_bank_reg;
                        rd_state_next = RD_PRIME;
                    end else begin
                        rd_state_next = RD_IDLE;
                    end
                end
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    // RAM word lands one cycle after issue; it goes straight to the output
    // register when that is free, otherwise it parks in the skid register.
    always_comb begin
        q_valid_next    = ram_re;
        q_idx_next      = ram_re ? ram_raddr_idx : q_idx_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_idx_next   = skid_idx_reg;
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_idx_next    = out_idx_reg;
        out_last_next   = out_last_reg;
        if (!out_valid_reg || fire) begin
            if (skid_valid_reg) begin
                out_valid_next  = 1'b1;
                out_data_next   = skid_data_reg;
                out_idx_next    = skid_idx_reg;
                out_last_next   = (skid_idx_reg == LAST_IDX);
                skid_valid_next = q_valid_reg;
                if (q_valid_reg) begin
                    skid_data_next = ram_q;
                    skid_idx_next  = q_idx_reg;
                end
            end else if (q_valid_reg) begin
                out_valid_next = 1'b1;
                out_data_next  = ram_q;
                out_idx_next   = q_idx_reg;
                out_last_next  = (q_idx_reg == LAST_IDX);
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (q_valid_reg) begin
            skid_valid_next = 1'b1;
            skid_data_next  = ram_q;
            skid_idx_next   = q_idx_reg;
        end
    end

    // ---------------- bank ownership ----------------
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_state_next[b] = bank_state_reg[b];
            if (wr_complete && (int'(wr_bank_reg) == b)) begin
                bank_state_next[b] = BANK_FULL;
            end
            if (rd_release && (int'(rd_bank_reg) == b)) begin
                bank_state_next[b] = BANK_EMPTY;
            end
            if (rd_take && (int'(rd_bank_next) == b)) begin
                bank_state_next[b] = BANK_READING;
            end
        end
        // The order flag only moves when a bank fills while the other is
        // not already waiting, so it always names the earlier frame.
        older_next = older_reg;
        if (wr_complete && (bank_state_reg[~wr_bank_reg] != BANK_FULL)) begin
            older_next = wr_bank_reg;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_state_reg   <= WR_FILL;
            wr_bank_reg    <= 1'b0;
            wr_idx_reg     <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_state_reg[b] <= BANK_EMPTY;
            end
            older_reg      <= 1'b0;
            rd_state_reg   <= RD_IDLE;
            rd_bank_reg    <= 1'b0;
            rd_ptr_reg     <= '0;
            issue_more_reg <= 1'b0;
            q_valid_reg    <= 1'b0;
            q_idx_reg      <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_idx_reg   <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_idx_reg    <= '0;
            out_last_reg   <= 1'b0;
            drop_reg       <= 1'b0;
        end else begin
            wr_state_reg   <= wr_state_next;
            wr_bank_reg    <= wr_bank_next;
            wr_idx_reg     <= wr_idx_next;
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_state_reg[b] <= bank_state_next[b];
            end
            older_reg      <= older_next;
            rd_state_reg   <= rd_state_next;
            rd_bank_reg    <= rd_bank_next;
            rd_ptr_reg     <= rd_ptr_next;
            issue_more_reg <= issue_more_next;
            q_valid_reg    <= q_valid_next;
            q_idx_reg      <= q_idx_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_idx_reg   <= skid_idx_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_idx_reg    <= out_idx_next;
            out_last_reg   <= out_last_next;
            drop_reg       <= drop_next;
        end
    end

    assign frame_data_out  = out_data_reg;
    assign frame_valid_out = out_valid_reg;
    assign frame_last_out  = out_last_reg;
    assign frame_index_out = out_idx_reg;
    assign drop_out        = drop_reg;

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer with FRAME_LEN = 8.
module tb_sample_framer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid_in = 1'b0;
    logic [15:0] frame_data_out;
    logic        frame_valid_out;
    logic        frame_ready_in = 1'b0;
    logic        frame_last_out;
    logic [2:0]  frame_index_out;
    logic        drop_out;

    sample_framer #(
        .SAMPLE_WIDTH (16),
        .FRAME_LEN    (8)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .frame_data_out  (frame_data_out),
        .frame_valid_out (frame_valid_out),
        .frame_ready_in  (frame_ready_in),
        .frame_last_out  (frame_last_out),
        .frame_index_out (frame_index_out),
        .drop_out        (drop_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  idx;
        logic        last;
        int          cyc;
    } beat_t;

    int    n_cmp  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    int    first_valid_cyc = -1;
    beat_t beats[$];
    int    drops[$];
    int    strobes[$];

    logic        obs_valid, obs_last, obs_drop, obs_ready;
    logic [15:0] obs_data;
    logic [2:0]  obs_idx;

    // One clock cycle: observe outputs mid-cycle, log transfers, then
    // advance to just after the next rising edge and clear the strobe.
    task automatic step();
        beat_t b;
        @(negedge clk_in);
        obs_valid = frame_valid_out;
        obs_last  = frame_last_out;
        obs_data  = frame_data_out;
        obs_idx   = frame_index_out;
        obs_drop  = drop_out;
        obs_ready = frame_ready_in;
        if (frame_valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (frame_valid_out && frame_ready_in) begin
            b.data = frame_data_out;
            b.idx  = frame_index_out;
            b.last = frame_last_out;
            b.cyc  = cyc;
            beats.push_back(b);
            $display("beat   cyc=%0d data=%h idx=%0d last=%0b", cyc, b.data, b.idx, b.last);
        end
        if (drop_out) begin
            drops.push_back(cyc);
            $display("drop   cyc=%0d", cyc);
        end
        if (sample_valid_in) strobes.push_back(cyc);
        @(posedge clk_in);
        #1;
        sample_valid_in = 1'b0;
        cyc++;
    endtask

    task automatic clear_logs();
        beats.delete();
        drops.delete();
        strobes.delete();
        cyc = 0;
        first_valid_cyc = -1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        sample_valid_in = 1'b0;
        frame_ready_in = 1'b0;
        repeat (3) step();
        rst_in = 1'b0;
        clear_logs();
    endtask

    // n samples, one every 2 cycles, values first, first+1, ...
    task automatic feed(input logic [15:0] first, input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            sample_in = first + 16'(i);
            sample_valid_in = 1'b1;
            frame_ready_in = rdy;
            step();
            frame_ready_in = rdy;
            step();
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            frame_ready_in = rdy;
            step();
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        sample_valid_in = 1'b0;
        frame_ready_in = 1'b1;
        repeat (3) step();
        n_cmp++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", obs_valid); end
        n_cmp++; if (obs_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b want=0", obs_last); end
        n_cmp++; if (obs_idx !== 3'd0) begin n_fail++; $display("FAIL reset_index got=%0d want=0", obs_idx); end
        n_cmp++; if (obs_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data got=%h want=0000", obs_data); end
        n_cmp++; if (obs_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%b want=0", obs_drop); end
        rst_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (obs_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_valid cyc=%0d got=%b want=0", i, obs_valid);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        do_reset();
        feed(16'h0001, 8, 1'b1);
        idle(20, 1'b1);
        n_cmp++;
        if (beats.size() != 8) begin n_fail++; $display("FAIL single_count got=%0d want=8", beats.size()); end
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            n_cmp++;
            if (beats[i].data !== 16'h0001 + 16'(i) || beats[i].idx !== 3'(i) || beats[i].last !== (i == 7)) begin
                n_fail++;
                $display("FAIL single_beat%0d got=%h/%0d/%0b want=%h/%0d/%0b", i,
                         beats[i].data, beats[i].idx, beats[i].last, 16'h0001 + 16'(i), i, (i == 7));
            end
        end
        if (strobes.size() == 8) begin
            n_cmp++;
            if (first_valid_cyc != strobes[7] + 3) begin
                n_fail++;
                $display("FAIL single_latency got=%0d want=%0d", first_valid_cyc, strobes[7] + 3);
            end
        end
        if (beats.size() == 8) begin
            n_cmp++;
            if (beats[7].cyc - beats[0].cyc != 7) begin
                n_fail++;
                $display("FAIL single_contiguous got=%0d want=7", beats[7].cyc - beats[0].cyc);
            end
        end
        $display("test_single_frame done");
    endtask

    task automatic test_backpressure();
        logic [15:0] pat;
        logic        prev_valid, prev_ready, prev_last;
        logic [15:0] prev_data;
        logic [2:0]  prev_idx;
        pat = 16'b1001_1010_0110_1001;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_last  = 1'b0;
        prev_data  = '0;
        prev_idx   = '0;
        do_reset();
        for (int c = 0; c < 80; c++) begin
            if (c < 16 && (c % 2) == 0) begin
                sample_in = 16'h0101 + 16'(c / 2);
                sample_valid_in = 1'b1;
            end
            frame_ready_in = pat[c % 16];
            step();
            if (prev_valid && !prev_ready) begin
                n_cmp++;
                if (obs_valid !== 1'b1 || obs_data !== prev_data || obs_idx !== prev_idx || obs_last !== prev_last) begin
                    n_fail++;
                    $display("FAIL bp_hold cyc=%0d got=%b/%h/%0d/%0b want=1/%h/%0d/%0b", c,
                             obs_valid, obs_data, obs_idx, obs_last, prev_data, prev_idx, prev_last);
                end
            end
            prev_valid = obs_valid;
            prev_ready = obs_ready;
            prev_data  = obs_data;
            prev_idx   = obs_idx;
            prev_last  = obs_last;
        end
        n_cmp++;
        if (beats.size() != 8) begin n_fail++; $display("FAIL bp_count got=%0d want=8", beats.size()); end
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            n_cmp++;
            if (beats[i].data !== 16'h0101 + 16'(i) || beats[i].idx !== 3'(i) || beats[i].last !== (i == 7)) begin
                n_fail++;
                $display("FAIL bp_beat%0d got=%h/%0d/%0b want=%h/%0d/%0b", i,
                         beats[i].data, beats[i].idx, beats[i].last, 16'h0101 + 16'(i), i, (i == 7));
            end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_overflow();
        do_reset();
        feed(16'h0201, 24, 1'b0);
        n_cmp++;
        if (drops.size() != 8) begin n_fail++; $display("FAIL ovf_drop_count got=%0d want=8", drops.size()); end
        for (int k = 0; k < drops.size() && k < 8; k++) begin
            n_cmp++;
            if (drops[k] != strobes[16 + k] + 1) begin
                n_fail++;
                $display("FAIL ovf_drop%0d got=%0d want=%0d", k, drops[k], strobes[16 + k] + 1);
            end
        end
        n_cmp++;
        if (beats.size() != 0) begin n_fail++; $display("FAIL ovf_no_beats_stalled got=%0d want=0", beats.size()); end
        idle(50, 1'b1);
        feed(16'h0301, 8, 1'b1);
        idle(20, 1'b1);
        n_cmp++;
        if (beats.size() != 24) begin n_fail++; $display("FAIL ovf_count got=%0d want=24", beats.size()); end
        for (int i = 0; i < beats.size() && i < 24; i++) begin
            logic [15:0] exp_d;
            exp_d = (i < 16) ? 16'h0201 + 16'(i) : 16'h0301 + 16'(i - 16);
            n_cmp++;
            if (beats[i].data !== exp_d || beats[i].idx !== 3'(i % 8) || beats[i].last !== ((i % 8) == 7)) begin
                n_fail++;
                $display("FAIL ovf_beat%0d got=%h/%0d/%0b want=%h/%0d/%0b", i,
                         beats[i].data, beats[i].idx, beats[i].last, exp_d, i % 8, ((i % 8) == 7));
            end
        end
        $display("test_overflow done");
    endtask

    task automatic test_collision();
        logic hit;
        int   hit_cyc;
        logic found;
        hit = 1'b0;
        hit_cyc = -1;
        found = 1'b0;
        do_reset();
        feed(16'h0401, 16, 1'b0);
        for (int c = 0; c < 40; c++) begin
            frame_ready_in = 1'b1;
            if (!hit && frame_valid_out && frame_last_out) begin
                sample_in = 16'h04FF;
                sample_valid_in = 1'b1;
                hit = 1'b1;
                hit_cyc = cyc;
            end
            step();
        end
        n_cmp++;
        if (hit !== 1'b1) begin n_fail++; $display("FAIL coll_last_seen got=%b want=1", hit); end
        foreach (drops[k]) if (drops[k] == hit_cyc + 1) found = 1'b1;
        n_cmp++;
        if (found !== 1'b1 || drops.size() != 1) begin
            n_fail++;
            $display("FAIL coll_drop got=%0b/%0d want=1/1", found, drops.size());
        end
        if (beats.size() >= 8) begin
            n_cmp++;
            if (beats[7].cyc != hit_cyc) begin
                n_fail++;
                $display("FAIL coll_same_cycle got=%0d want=%0d", beats[7].cyc, hit_cyc);
            end
        end
        feed(16'h0501, 8, 1'b1);
        idle(20, 1'b1);
        n_cmp++;
        if (beats.size() != 24) begin n_fail++; $display("FAIL coll_count got=%0d want=24", beats.size()); end
        for (int i = 0; i < beats.size() && i < 24; i++) begin
            logic [15:0] exp_d;
            exp_d = (i < 16) ? 16'h0401 + 16'(i) : 16'h0501 + 16'(i - 16);
            n_cmp++;
            if (beats[i].data !== exp_d || beats[i].idx !== 3'(i % 8)) begin
                n_fail++;
                $display("FAIL coll_beat%0d got=%h/%0d want=%h/%0d", i,
                         beats[i].data, beats[i].idx, exp_d, i % 8);
            end
        end
        $display("test_collision done");
    endtask

    task automatic test_mid_reset();
        logic hit;
        hit = 1'b0;
        do_reset();
        for (int c = 0; c < 40 && !hit; c++) begin
            if (c < 16 && (c % 2) == 0) begin
                sample_in = 16'h0601 + 16'(c / 2);
                sample_valid_in = 1'b1;
            end
            frame_ready_in = 1'b1;
            if (frame_valid_out && frame_index_out == 3'd4) begin
                rst_in = 1'b1;
                hit = 1'b1;
            end
            step();
        end
        rst_in = 1'b0;
        n_cmp++;
        if (hit !== 1'b1) begin n_fail++; $display("FAIL mrst_beat4_seen got=%b want=1", hit); end
        step();
        n_cmp++;
        if (obs_valid !== 1'b0 || obs_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL mrst_valid_falls got=%b/%0d want=0/0", obs_valid, obs_idx);
        end
        clear_logs();
        idle(20, 1'b1);
        n_cmp++;
        if (beats.size() != 0) begin n_fail++; $display("FAIL mrst_no_partial got=%0d want=0", beats.size()); end
        feed(16'h0701, 8, 1'b1);
        idle(20, 1'b1);
        n_cmp++;
        if (beats.size() != 8) begin n_fail++; $display("FAIL mrst_count got=%0d want=8", beats.size()); end
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            n_cmp++;
            if (beats[i].data !== 16'h0701 + 16'(i) || beats[i].idx !== 3'(i) || beats[i].last !== (i == 7)) begin
                n_fail++;
                $display("FAIL mrst_beat%0d got=%h/%0d/%0b want=%h/%0d/%0b", i,
                         beats[i].data, beats[i].idx, beats[i].last, 16'h0701 + 16'(i), i, (i == 7));
            end
        end
        $display("test_mid_reset done");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_collision();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
